// File: rtl/ctrl_sequencer_pkg.sv
// rtl/ctrl_sequencer_pkg.sv - opcodes, FSM state encoding and operand field positions
package ctrl_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_OPERAND = 3'd2,
    ST_LITERAL = 3'd3,
    ST_EXEC    = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_MOV_REG_LIT = 8'h10;
  localparam logic [7:0] OP_MOV_REG_REG = 8'h11;
  localparam logic [7:0] OP_HALT        = 8'hFF;

  // Operand byte layout: destination in the low nibble, source in the high nibble.
  localparam int DST_LSB = 0;
  localparam int SRC_LSB = 4;
  localparam int FIELD_W = 4;

  // Number of bus beats needed to assemble one register-wide literal.
  function automatic int lit_bytes(input int word_size, input int byte_size);
    return word_size / byte_size;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// rtl/ctrl_sequencer_if.sv - byte bus and register file interface of the sequencer
interface ctrl_sequencer_if #(
  parameter int BYTE_SIZE = 8,
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4,
  parameter int REG_IDX_W = $clog2(NUM_REGS)
);

  logic [BYTE_SIZE-1:0] ext_data_bus;
  logic                 mem_ready;
  logic                 read_en;
  logic                 pc_inc;
  logic                 ir_ld;
  logic [BYTE_SIZE-1:0] instr;
  logic [NUM_REGS-1:0]  reg_ld;
  logic [WORD_SIZE-1:0] reg_wdata;
  logic [REG_IDX_W-1:0] reg_rsel;
  logic [WORD_SIZE-1:0] reg_rdata;
  logic                 halted;
  logic                 illegal;

  modport master (
    input  ext_data_bus, mem_ready, reg_rdata,
    output read_en, pc_inc, ir_ld, instr, reg_ld, reg_wdata, reg_rsel, halted, illegal
  );

  modport slave (
    output ext_data_bus, mem_ready, reg_rdata,
    input  read_en, pc_inc, ir_ld, instr, reg_ld, reg_wdata, reg_rsel, halted, illegal
  );

endinterface

// File: rtl/ctrl_sequencer_operand_assembler.sv
// rtl/ctrl_sequencer_operand_assembler.sv - little-endian literal assembler with byte counter
module operand_assembler #(
  parameter int BYTE_SIZE = 8,
  parameter int LIT_BYTES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_clear,
  input  logic                           i_load,
  input  logic [BYTE_SIZE-1:0]           i_byte,
  output logic [BYTE_SIZE*LIT_BYTES-1:0] o_literal,
  output logic                           o_last
);

  localparam int CNT_W = (LIT_BYTES > 1) ? $clog2(LIT_BYTES) : 1;

  logic [CNT_W-1:0]               r_count;
  logic [BYTE_SIZE*LIT_BYTES-1:0] r_literal;
  logic                           w_last;

  // The counter indexes the byte being received; it parks on the last byte.
  assign w_last    = (32'(r_count) == LIT_BYTES - 1);
  assign o_last    = w_last;
  assign o_literal = r_literal;

  // Byte k of the literal lands at bits [k*BYTE_SIZE +: BYTE_SIZE].
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count   <= '0;
      r_literal <= '0;
    end else if (i_load) begin
      r_literal[r_count*BYTE_SIZE +: BYTE_SIZE] <= i_byte;
      if (!w_last) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multi-cycle instruction sequencer; CTRL_SEQ_WAIT_STATES_EN honours mem_ready
module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int BYTE_SIZE = 8,
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4
) (
  input logic              clk,
  input logic              reset,
  ctrl_sequencer_if.master bus
);

  localparam int LIT_BYTES = lit_bytes(WORD_SIZE, BYTE_SIZE);
  localparam int REG_IDX_W = $clog2(NUM_REGS);

  localparam logic [BYTE_SIZE-1:0] W_OP_NOP = BYTE_SIZE'(OP_NOP);
  localparam logic [BYTE_SIZE-1:0] W_OP_LIT = BYTE_SIZE'(OP_MOV_REG_LIT);
  localparam logic [BYTE_SIZE-1:0] W_OP_RR  = BYTE_SIZE'(OP_MOV_REG_REG);
  localparam logic [BYTE_SIZE-1:0] W_OP_HLT = BYTE_SIZE'(OP_HALT);

  state_t               r_state;
  logic [BYTE_SIZE-1:0] r_ir;
  logic [BYTE_SIZE-1:0] r_operand;
  logic                 r_illegal;
  logic                 r_read_en;
  logic                 r_halted;
  logic [WORD_SIZE-1:0] r_wdata;

  logic                 w_ready;
  logic                 w_read_en;
  logic                 w_beat;
  logic                 w_asm_clear;
  logic                 w_asm_load;
  logic                 w_lit_last;
  logic [WORD_SIZE-1:0] w_literal;
  logic [FIELD_W-1:0]   w_dst;
  logic [FIELD_W-1:0]   w_src;
  logic                 w_is_lit;
  logic                 w_is_rr;
  logic                 w_dst_ok;
  logic                 w_src_ok;
  logic                 w_exec_ok;
  logic [WORD_SIZE-1:0] w_exec_data;
  logic [NUM_REGS-1:0]  w_reg_ld;

`ifdef CTRL_SEQ_WAIT_STATES_EN
  assign w_ready = bus.mem_ready;
`else
  logic w_unused_ready;
  assign w_unused_ready = bus.mem_ready;
  assign w_ready        = 1'b1;
`endif

  // A beat completes only while a read is actually requested; mem_ready is ignored elsewhere.
  assign w_read_en = r_read_en & ~reset;
  assign w_beat    = w_read_en & w_ready;

  assign w_is_lit  = (r_ir == W_OP_LIT);
  assign w_is_rr   = (r_ir == W_OP_RR);
  assign w_dst     = r_operand[DST_LSB +: FIELD_W];
  assign w_src     = r_operand[SRC_LSB +: FIELD_W];
  assign w_dst_ok  = (32'(w_dst) < NUM_REGS);
  assign w_src_ok  = !w_is_rr || (32'(w_src) < NUM_REGS);
  assign w_exec_ok = w_dst_ok && w_src_ok;

  assign w_exec_data = w_is_rr ? bus.reg_rdata : w_literal;
  assign w_reg_ld    = (r_state == ST_EXEC && w_exec_ok && !reset) ? (NUM_REGS'(1) << w_dst) : '0;

  // The literal restarts from byte 0 when the operand of an instruction arrives.
  assign w_asm_clear = (r_state == ST_OPERAND) && w_beat;
  assign w_asm_load  = (r_state == ST_LITERAL) && w_beat;

  operand_assembler #(
    .BYTE_SIZE(BYTE_SIZE),
    .LIT_BYTES(LIT_BYTES)
  ) u_operand_assembler (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_asm_clear),
    .i_load   (w_asm_load),
    .i_byte   (bus.ext_data_bus),
    .o_literal(w_literal),
    .o_last   (w_lit_last)
  );

  // Sequencer FSM; read_en and halted are registered alongside the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_ir      <= '0;
      r_operand <= '0;
      r_illegal <= 1'b0;
      r_read_en <= 1'b1;
      r_halted  <= 1'b0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_ready) begin
            r_ir      <= bus.ext_data_bus;
            r_operand <= '0;
            r_read_en <= 1'b0;
            r_state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (r_ir == W_OP_NOP) begin
            r_read_en <= 1'b1;
            r_state   <= ST_FETCH;
          end else if (r_ir == W_OP_HLT) begin
            r_halted  <= 1'b1;
            r_state   <= ST_HALT;
          end else if (w_is_lit || w_is_rr) begin
            r_read_en <= 1'b1;
            r_state   <= ST_OPERAND;
          end else begin
            r_illegal <= 1'b1;
            r_read_en <= 1'b1;
            r_state   <= ST_FETCH;
          end
        end
        ST_OPERAND: begin
          if (w_ready) begin
            r_operand <= bus.ext_data_bus;
            if (w_is_lit) begin
              r_state   <= ST_LITERAL;
            end else begin
              r_read_en <= 1'b0;
              r_state   <= ST_EXEC;
            end
          end
        end
        ST_LITERAL: begin
          if (w_ready && w_lit_last) begin
            r_read_en <= 1'b0;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_wdata <= w_exec_data;
          if (!w_exec_ok) begin
            r_illegal <= 1'b1;
          end
          r_read_en <= 1'b1;
          r_state   <= ST_FETCH;
        end
        ST_HALT: begin
          r_read_en <= 1'b0;
          r_halted  <= 1'b1;
        end
        default: begin
          r_read_en <= 1'b1;
          r_state   <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.read_en   = w_read_en;
  assign bus.pc_inc    = w_beat;
  assign bus.ir_ld     = (r_state == ST_FETCH) && w_beat;
  assign bus.instr     = reset ? '0 : r_ir;
  assign bus.reg_ld    = w_reg_ld;
  assign bus.reg_wdata = reset ? '0 : ((r_state == ST_EXEC) ? w_exec_data : r_wdata);
  assign bus.reg_rsel  = w_is_rr ? w_src[REG_IDX_W-1:0] : '0;
  assign bus.halted    = r_halted & ~reset;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;

`ifdef CTRL_SEQ_WAIT_STATES_EN
  localparam int T3_LD = 9;
`else
  localparam int T3_LD = 6;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pc_clr = 1'b0;
  int   pc = 0;
  logic [7:0]  mem [64];
  logic [15:0] regs [4];

  int checks = 0;
  int failures = 0;
  int cyc, pc_cnt, ld_cycle, overlap;
  logic [3:0]  ld_val;
  logic [15:0] ld_wdata;
  logic [1:0]  ld_rsel;
  logic [7:0]  instr2;
  logic        ill3;

  always #5 clk = ~clk;

  ctrl_sequencer_if #(.BYTE_SIZE(8), .WORD_SIZE(16), .NUM_REGS(4)) bus ();

  ctrl_sequencer #(.BYTE_SIZE(8), .WORD_SIZE(16), .NUM_REGS(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.ext_data_bus = mem[pc[5:0]];
  assign bus.reg_rdata    = regs[bus.reg_rsel];

  always @(posedge clk) begin
    if (pc_clr) pc <= 0;
    else if (bus.pc_inc) pc <= pc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset(input logic clr_pc);
    reset = 1'b1;
    pc_clr = clr_pc;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_read_en", 32'(bus.read_en), 0);
    check("rst_pc_inc", 32'(bus.pc_inc), 0);
    check("rst_ir_ld", 32'(bus.ir_ld), 0);
    check("rst_reg_ld", 32'(bus.reg_ld), 0);
    check("rst_halted", 32'(bus.halted), 0);
    check("rst_wdata", 32'(bus.reg_wdata), 0);
    check("rst_instr", 32'(bus.instr), 0);
    @(negedge clk);
    reset = 1'b0;
    pc_clr = 1'b0;
    #1;
    check("post_rst_read_en", 32'(bus.read_en), 1);
    check("post_rst_illegal", 32'(bus.illegal), 0);
    cyc = 0; pc_cnt = 0; ld_cycle = 0; overlap = 0;
    ld_val = '0; ld_wdata = '0; ld_rsel = '0; instr2 = '0; ill3 = 1'b0;
  endtask

  task automatic step(input logic rdy);
    bus.mem_ready = rdy;
    #1;
    cyc++;
    if (bus.pc_inc) pc_cnt++;
    if (|bus.reg_ld) begin
      ld_cycle = cyc;
      ld_val   = bus.reg_ld;
      ld_wdata = bus.reg_wdata;
      ld_rsel  = bus.reg_rsel;
      if (bus.read_en) overlap++;
    end
    if (cyc == 2) instr2 = bus.instr;
    if (cyc == 3) ill3 = bus.illegal;
    @(negedge clk);
  endtask

  task automatic run(input int ncyc, input int st, input int sl);
    for (int i = 1; i <= ncyc; i++) step((i >= st && i < st + sl) ? 1'b0 : 1'b1);
  endtask

  initial begin
    bus.mem_ready = 1'b1;
    regs[0] = 16'h0000; regs[1] = 16'hBEEF; regs[2] = 16'h0000; regs[3] = 16'h0000;
    @(negedge clk);

    // MOV_REG_LIT r2, 0x1234 at zero wait
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h02; mem[2] = 8'h34; mem[3] = 8'h12;
    do_reset(1'b1);
    run(6, 0, 0);
    check("t1_instr", 32'(instr2), 32'h10);
    check("t1_ld_cycle", ld_cycle, 6);
    check("t1_ld_val", 32'(ld_val), 32'b0100);
    check("t1_wdata", 32'(ld_wdata), 32'h1234);
    check("t1_pc_inc", pc_cnt, 4);
    check("t1_overlap", overlap, 0);
    run(2, 0, 0);
    check("t1_wdata_hold", 32'(bus.reg_wdata), 32'h1234);
    check("t1_nop_refetch", 32'(bus.read_en), 1);

    // MOV_REG_REG r0 <- r1
    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'h10;
    do_reset(1'b1);
    run(4, 0, 0);
    check("t2_ld_cycle", ld_cycle, 4);
    check("t2_rsel", 32'(ld_rsel), 1);
    check("t2_ld_val", 32'(ld_val), 32'b0001);
    check("t2_wdata", 32'(ld_wdata), 32'hBEEF);
    check("t2_pc_inc", pc_cnt, 2);

    // MOV_REG_LIT r3, 0xABCD with mem_ready low for 3 cycles on the second literal byte
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h03; mem[2] = 8'hCD; mem[3] = 8'hAB;
    do_reset(1'b1);
    run(T3_LD, 5, 3);
    check("t3_ld_cycle", ld_cycle, T3_LD);
    check("t3_ld_val", 32'(ld_val), 32'b1000);
    check("t3_wdata", 32'(ld_wdata), 32'hABCD);
    check("t3_pc_inc", pc_cnt, 4);
    check("t3_overlap", overlap, 0);

    // Illegal opcode, then MOV_REG_LIT to r7, then NOP
    clear_mem();
    mem[0] = 8'h42; mem[1] = 8'h10; mem[2] = 8'h07; mem[3] = 8'h11; mem[4] = 8'h22;
    do_reset(1'b1);
    run(10, 0, 0);
    check("t4_illegal_early", 32'(ill3), 1);
    check("t4_no_ld", ld_cycle, 0);
    check("t4_illegal_sticky", 32'(bus.illegal), 1);
    check("t4_pc_inc", pc_cnt, 6);
    check("t4_instr_nop", 32'(bus.instr), 0);
    check("t4_fetch_next", 32'(bus.read_en), 1);

    // HALT stays halted until reset
    clear_mem();
    mem[0] = 8'hFF;
    do_reset(1'b1);
    run(10, 0, 0);
    check("t5_halted", 32'(bus.halted), 1);
    check("t5_read_en", 32'(bus.read_en), 0);
    check("t5_pc_inc", pc_cnt, 1);
    check("t5_illegal", 32'(bus.illegal), 0);

    // Reset during LITERAL abandons the instruction and fetches the current byte
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'h01; mem[2] = 8'h55; mem[3] = 8'hFF;
    do_reset(1'b1);
    run(4, 0, 0);
    check("t6_pc_before", pc, 3);
    do_reset(1'b0);
    run(3, 0, 0);
    check("t6_no_ld", ld_cycle, 0);
    check("t6_instr", 32'(instr2), 32'hFF);
    check("t6_halted", 32'(bus.halted), 1);
    check("t6_pc_inc", pc_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
